// File: rtl/bus_dev_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_dev_pkg
// Purpose  : Shared constants and helpers for the bus device port.
// Revision : 1.0 - initial release
// ============================================================================
package bus_dev_pkg;

  // Width of a device id carried in the top bits of every packet.
  localparam int ID_W = 8;

  // Destination id that every port accepts.
  localparam logic [ID_W-1:0] BROADCAST_ID = 8'hFF;

  // Widest packet dest_of() can inspect.
  localparam int MAX_PKT_W = 64;

  typedef logic [ID_W-1:0] dev_id_t;

  // Destination id of a packet: its top ID_W bits. The packet is passed
  // zero-extended to MAX_PKT_W along with its true width.
  function automatic dev_id_t dest_of(input logic [MAX_PKT_W-1:0] pkt,
                                      input int                   pkt_w);
    logic [MAX_PKT_W-1:0] shifted;
    shifted = pkt >> (pkt_w - ID_W);
    return shifted[ID_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_dev_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_dev_if
// Purpose  : Host-side handshake and bus-side pop/push signals of one
//            device port. slave = the port, master = host + bus.
// Revision : 1.0 - initial release
// ============================================================================
interface bus_dev_if #(
  parameter int pckg_sz = 16
);
  // Host TX side
  logic               tx_valid;
  logic               tx_ready;
  logic [pckg_sz-1:0] tx_data;
  // Host RX side
  logic               rx_valid;
  logic               rx_ready;
  logic [pckg_sz-1:0] rx_data;
  // Bus side
  logic               pndng;
  logic [pckg_sz-1:0] D_pop;
  logic               pop;
  logic               push;
  logic [pckg_sz-1:0] D_push;

  modport slave (
    input  tx_valid, tx_data, rx_ready, pop, push, D_push,
    output tx_ready, rx_valid, rx_data, pndng, D_pop
  );

  modport master (
    output tx_valid, tx_data, rx_ready, pop, push, D_push,
    input  tx_ready, rx_valid, rx_data, pndng, D_pop
  );
endinterface
`default_nettype wire

// File: rtl/bus_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bus_sync_fifo
// Purpose  : First-word-fall-through synchronous FIFO of any depth >= 2.
//            A push while full is taken only if a pop happens in the same
//            cycle; dout reads 0 while empty.
// Revision : 1.0 - initial release
// ============================================================================
module bus_sync_fifo #(
  parameter int width = 16,
  parameter int depth = 8
) (
  input  wire logic                       clk,
  input  wire logic                       reset,
  input  wire logic                       push,
  input  wire logic                       pop,
  input  wire logic [width-1:0]           din,
  output logic      [width-1:0]           dout,
  output logic      [$clog2(depth+1)-1:0] count,
  output logic                            full,
  output logic                            empty
);
  localparam int c_ptr_w = $clog2(depth);
  localparam int c_cnt_w = $clog2(depth + 1);
  localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(depth - 1);
  localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(depth);

  logic [width-1:0]   r_mem [depth];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               w_do_push;
  logic               w_do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [c_ptr_w-1:0] next_ptr(input logic [c_ptr_w-1:0] p);
    return (p == c_last_ptr) ? '0 : p + 1'b1;
  endfunction

  assign w_do_pop  = pop && (r_count != '0);
  assign w_do_push = push && ((r_count != c_depth) || w_do_pop);

  assign count = r_count;
  assign full  = (r_count == c_depth);
  assign empty = (r_count == '0);
  assign dout  = empty ? '0 : r_mem[r_rd_ptr];

  // Storage array; contents need no reset because dout is gated by empty.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/bus_dev_port.sv
`default_nettype none
// ============================================================================
// Module   : bus_dev_port
// Purpose  : Device-side endpoint of one bus port. Host packets queue in a
//            TX FIFO offered to the bus via pndng/D_pop/pop; bus deliveries
//            on push/D_push land in an RX FIFO for the host.
//            Macro BUS_PORT_DEST_FILTER_EN: when defined, only packets whose
//            destination is dev_id or broadcast are accepted; otherwise every
//            push is accepted (bus-monitor mode).
// Revision : 1.0 - initial release
// ============================================================================
module bus_dev_port
  import bus_dev_pkg::*;
#(
  parameter int      pckg_sz   = 16,
  parameter int      fifo_size = 8,
  parameter dev_id_t dev_id    = 8'h00,
  parameter dev_id_t broadcast = BROADCAST_ID
) (
  input  wire logic                           clk,
  input  wire logic                           reset,
  bus_dev_if.slave                            bus,
  output logic      [$clog2(fifo_size+1)-1:0] tx_count,
  output logic      [$clog2(fifo_size+1)-1:0] rx_count,
  output logic      [7:0]                     rx_drop_cnt,
  output logic                                tx_underflow
);
  logic       w_tx_full;
  logic       w_tx_empty;
  logic       w_rx_full;
  logic       w_rx_empty;
  logic       w_accept;
  logic       w_drop;
  logic [7:0] r_drop_cnt;
  logic       r_tx_underflow;

  // ---------------------------------------------------------------- TX path
  assign bus.tx_ready = !w_tx_full;
  assign bus.pndng    = !w_tx_empty;

  bus_sync_fifo #(
    .width (pckg_sz),
    .depth (fifo_size)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.tx_valid && !w_tx_full),
    .pop   (bus.pop),
    .din   (bus.tx_data),
    .dout  (bus.D_pop),
    .count (tx_count),
    .full  (w_tx_full),
    .empty (w_tx_empty)
  );

  // Sticky flag: the bus popped while nothing was pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_underflow <= 1'b0;
    end else if (bus.pop && w_tx_empty) begin
      r_tx_underflow <= 1'b1;
    end
  end

  assign tx_underflow = r_tx_underflow;

  // ---------------------------------------------------------------- RX path
`ifdef BUS_PORT_DEST_FILTER_EN
  dev_id_t w_dest;
  assign w_dest   = dest_of(MAX_PKT_W'(bus.D_push), pckg_sz);
  assign w_accept = bus.push && ((w_dest == dev_id) || (w_dest == broadcast));
`else
  assign w_accept = bus.push;
`endif

  // Full implies not empty, so rx_ready alone tells whether a slot frees.
  assign w_drop = w_accept && w_rx_full && !bus.rx_ready;

  bus_sync_fifo #(
    .width (pckg_sz),
    .depth (fifo_size)
  ) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_accept),
    .pop   (bus.rx_ready),
    .din   (bus.D_push),
    .dout  (bus.rx_data),
    .count (rx_count),
    .full  (w_rx_full),
    .empty (w_rx_empty)
  );

  assign bus.rx_valid = !w_rx_empty;

  // Saturating count of accepted packets lost to a full RX FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_drop_cnt <= 8'd0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign rx_drop_cnt = r_drop_cnt;
endmodule
`default_nettype wire

// File: tb/tb_bus_dev_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_dev_port
// Purpose  : Self-checking bench for bus_dev_port (dev_id=2, 16-bit packets,
//            depth 8) with a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_dev_port;
  localparam int         PW    = 16;
  localparam int         DEPTH = 8;
  localparam int         CW    = $clog2(DEPTH + 1);
  localparam logic [7:0] DEV   = 8'd2;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic [CW-1:0] tx_count;
  logic [CW-1:0] rx_count;
  logic [7:0]    rx_drop_cnt;
  logic          tx_underflow;

  always #5 clk = ~clk;

  bus_dev_if #(.pckg_sz(PW)) bif ();

  bus_dev_port #(
    .pckg_sz   (PW),
    .fifo_size (DEPTH),
    .dev_id    (DEV),
    .broadcast (8'hFF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bif.slave),
    .tx_count     (tx_count),
    .rx_count     (rx_count),
    .rx_drop_cnt  (rx_drop_cnt),
    .tx_underflow (tx_underflow)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  logic [PW-1:0] m_tx[$];
  logic [PW-1:0] m_rx[$];
  int            m_drop = 0;
  bit            m_uf   = 1'b0;

  function automatic bit accepts(input logic [PW-1:0] p);
`ifdef BUS_PORT_DEST_FILTER_EN
    return (p[PW-1 -: 8] == DEV) || (p[PW-1 -: 8] == 8'hFF);
`else
    return (p == p);
`endif
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_tx.delete();
      m_rx.delete();
      m_drop <= 0;
      m_uf   <= 1'b0;
    end else begin
      // TX: a write needs room before this edge; a pop needs data before it.
      if (bif.pop && m_tx.size() == 0) m_uf <= 1'b1;
      if (bif.pop && m_tx.size() > 0) begin
        if (bif.tx_valid && m_tx.size() < DEPTH) m_tx.push_back(bif.tx_data);
        void'(m_tx.pop_front());
      end else if (bif.tx_valid && m_tx.size() < DEPTH) begin
        m_tx.push_back(bif.tx_data);
      end
      // RX: a full queue still takes the packet if the host reads this cycle.
      if (bif.push && accepts(bif.D_push) && m_rx.size() >= DEPTH && !bif.rx_ready
          && m_drop < 255)
        m_drop <= m_drop + 1;
      if (bif.rx_ready && m_rx.size() > 0) void'(m_rx.pop_front());
      if (bif.push && accepts(bif.D_push) && m_rx.size() < DEPTH) m_rx.push_back(bif.D_push);
    end
  end

  function automatic logic [PW-1:0] head_of_tx();
    return (m_tx.size() > 0) ? m_tx[0] : '0;
  endfunction

  function automatic logic [PW-1:0] head_of_rx();
    return (m_rx.size() > 0) ? m_rx[0] : '0;
  endfunction

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("tx_ready",     32'(bif.tx_ready),  32'(m_tx.size() != DEPTH));
      chk("pndng",        32'(bif.pndng),     32'(m_tx.size() != 0));
      chk("D_pop",        32'(bif.D_pop),     32'(head_of_tx()));
      chk("tx_count",     32'(tx_count),      32'(m_tx.size()));
      chk("rx_valid",     32'(bif.rx_valid),  32'(m_rx.size() != 0));
      chk("rx_data",      32'(bif.rx_data),   32'(head_of_rx()));
      chk("rx_count",     32'(rx_count),      32'(m_rx.size()));
      chk("rx_drop_cnt",  32'(rx_drop_cnt),   32'(m_drop));
      chk("tx_underflow", 32'(tx_underflow),  32'(m_uf));
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_pkt(input logic [PW-1:0] p);
    bif.push   = 1'b1;
    bif.D_push = p;
    tick();
    bif.push   = 1'b0;
  endtask

  task automatic drain_rx();
    bif.rx_ready = 1'b1;
    for (int k = 0; k < 20 && bif.rx_valid; k++) tick();
    bif.rx_ready = 1'b0;
    chk("rx_drain_done", 32'(bif.rx_valid), 32'd0);
  endtask

  initial begin
    bif.tx_valid = 1'b0;
    bif.tx_data  = '0;
    bif.rx_ready = 1'b0;
    bif.pop      = 1'b0;
    bif.push     = 1'b0;
    bif.D_push   = '0;

    tick();
    tick();
    cmp_en = 1'b1;
    tick();
    reset = 1'b1;
    tick();

    // Reset state
    chk("rst_tx_ready", 32'(bif.tx_ready), 32'd1);
    chk("rst_pndng",    32'(bif.pndng),    32'd0);
    chk("rst_rx_valid", 32'(bif.rx_valid), 32'd0);
    chk("rst_D_pop",    32'(bif.D_pop),    32'd0);

    // RX filtering
    push_pkt(16'h02AB);
    chk("rx_first_valid", 32'(bif.rx_valid), 32'd1);
    chk("rx_first_data",  32'(bif.rx_data),  32'h02AB);
    chk("rx_first_count", 32'(rx_count),     32'd1);
    push_pkt(16'h03CD);
`ifdef BUS_PORT_DEST_FILTER_EN
    chk("rx_other_dest", 32'(rx_count), 32'd1);
`else
    chk("rx_other_dest", 32'(rx_count), 32'd2);
`endif
    push_pkt(16'hFF11);
`ifdef BUS_PORT_DEST_FILTER_EN
    chk("rx_broadcast", 32'(rx_count), 32'd2);
`else
    chk("rx_broadcast", 32'(rx_count), 32'd3);
`endif
    drain_rx();

    // RX overflow and the read-frees-a-slot exception
    for (int i = 0; i < 9; i++) push_pkt(16'h0230 + 16'(i));
    chk("rx_full_count", 32'(rx_count),    32'd8);
    chk("rx_drop_one",   32'(rx_drop_cnt), 32'd1);
    bif.rx_ready = 1'b1;
    push_pkt(16'h02A0);
    bif.rx_ready = 1'b0;
    chk("rx_swap_count", 32'(rx_count),    32'd8);
    chk("rx_swap_drop",  32'(rx_drop_cnt), 32'd1);
    chk("rx_swap_head",  32'(bif.rx_data), 32'h0231);
    drain_rx();

    // TX fill, overfill attempt, drain in order
    for (int i = 0; i < 9; i++) begin
      bif.tx_valid = 1'b1;
      bif.tx_data  = 16'h0100 + 16'(i);
      tick();
    end
    bif.tx_valid = 1'b0;
    chk("tx_full_ready", 32'(bif.tx_ready), 32'd0);
    chk("tx_full_count", 32'(tx_count),     32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("tx_pop_order", 32'(bif.D_pop), 32'(16'h0100 + 16'(i)));
      bif.pop = 1'b1;
      tick();
    end
    bif.pop = 1'b0;
    chk("tx_empty_pndng", 32'(bif.pndng), 32'd0);

    // Underflow
    bif.pop = 1'b1;
    tick();
    bif.pop = 1'b0;
    chk("tx_underflow_set",   32'(tx_underflow), 32'd1);
    chk("tx_underflow_count", 32'(tx_count),     32'd0);

    // Simultaneous write and pop at count 3
    for (int i = 0; i < 3; i++) begin
      bif.tx_valid = 1'b1;
      bif.tx_data  = 16'h0200 + 16'(i);
      tick();
    end
    bif.tx_data = 16'h0210;
    bif.pop     = 1'b1;
    tick();
    bif.tx_valid = 1'b0;
    bif.pop      = 1'b0;
    chk("tx_wr_pop_count", 32'(tx_count),  32'd3);
    chk("tx_wr_pop_head",  32'(bif.D_pop), 32'h0201);

    // Build up tx_count=5, rx_count=4, then reset mid-stream
    for (int i = 0; i < 2; i++) begin
      bif.tx_valid = 1'b1;
      bif.tx_data  = 16'h0220 + 16'(i);
      tick();
    end
    bif.tx_valid = 1'b0;
    for (int i = 0; i < 4; i++) push_pkt(16'h0240 + 16'(i));
    chk("pre_rst_tx_count", 32'(tx_count), 32'd5);
    chk("pre_rst_rx_count", 32'(rx_count), 32'd4);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_pndng",    32'(bif.pndng),    32'd0);
    chk("async_rst_rx_valid", 32'(bif.rx_valid), 32'd0);
    chk("async_rst_tx_count", 32'(tx_count),     32'd0);
    chk("async_rst_rx_count", 32'(rx_count),     32'd0);
    chk("async_rst_uf",       32'(tx_underflow), 32'd0);
    chk("async_rst_drop",     32'(rx_drop_cnt),  32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst_tx_ready", 32'(bif.tx_ready), 32'd1);
    tick();
    cmp_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
